// File: rtl/hub75_pkg.sv
// Shared HUB75 constants: FSM state encodings, RGB bit positions and panel defaults.
package hub75_pkg;

  localparam int HUB75_COLS = 64;
  localparam int HUB75_ROWS = 32;

  localparam logic [0:0] ST_NO_TOKEN = 1'b0;
  localparam logic [0:0] ST_TRACKING = 1'b1;

  localparam logic [0:0] ST_BLANKED  = 1'b0;
  localparam logic [0:0] ST_LIT      = 1'b1;

  // Bit positions inside the 6-bit {R1,G1,B1,R2,G2,B2} bus
  localparam int RGB_R1 = 5;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 3;
  localparam int RGB_R2 = 2;
  localparam int RGB_G2 = 1;
  localparam int RGB_B2 = 0;

endpackage

// File: rtl/hub75_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin bus plus one edge-detect stage.
module hub75_pin_sync #(
  parameter int             W           = 1,
  parameter int             SYNC_STAGES = 2,
  parameter logic [W-1:0]   RST_VAL     = '0
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic [W-1:0] pin,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d[0] = pin;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/hub75_rx_monitor.sv
// HUB75 receive-side monitor: rebuilds column shifts, latches, row position and lit
// intervals from the panel pins, reporting each as a registered one-cycle pulse.
module hub75_rx_monitor import hub75_pkg::*; #(
  parameter int COLS        = HUB75_COLS,
  parameter int ROWS        = HUB75_ROWS,
  parameter int SYNC_STAGES = 2,
  parameter int ON_W        = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       in_clk,
  input  logic [5:0]                 in_rgb,
  input  logic                       in_lat,
  input  logic                       in_blank,
  input  logic                       in_row_clk,
  input  logic                       in_row_data,
  output logic                       px_valid,
  output logic [$clog2(COLS+1)-1:0]  px_col,
  output logic [5:0]                 px_rgb,
  output logic                       lat_valid,
  output logic [$clog2(COLS+1)-1:0]  lat_cols,
  output logic [$clog2(ROWS)-1:0]    lat_row,
  output logic                       lat_ovf,
  output logic                       on_valid,
  output logic [ON_W-1:0]            on_cycles,
  output logic [$clog2(ROWS)-1:0]    on_row,
  output logic                       row_valid,
  output logic                       frame_start
);

  localparam int CW = $clog2(COLS+1);
  localparam int RW = $clog2(ROWS);

  logic       clk_rise, lat_rise, blank_rise, blank_fall, row_rise, row_data_lvl;
  logic [5:0] rgb_lvl;
  logic       clk_lvl_unused, clk_fall_unused, lat_lvl_unused, lat_fall_unused;
  logic       blank_lvl_unused, row_lvl_unused, row_fall_unused;
  logic       row_data_rise_unused, row_data_fall_unused;
  logic [5:0] rgb_rise_unused, rgb_fall_unused;

  hub75_pin_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .sys_clk(sys_clk), .rst(rst), .pin(in_clk),
    .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall_unused));

  hub75_pin_sync #(.W(6), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(6'd0)) u_sync_rgb (
    .sys_clk(sys_clk), .rst(rst), .pin(in_rgb),
    .level(rgb_lvl), .rise(rgb_rise_unused), .fall(rgb_fall_unused));

  hub75_pin_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
    .sys_clk(sys_clk), .rst(rst), .pin(in_lat),
    .level(lat_lvl_unused), .rise(lat_rise), .fall(lat_fall_unused));

  // Blank idles high, so its flops reset high to avoid a phantom lit period.
  hub75_pin_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_blank (
    .sys_clk(sys_clk), .rst(rst), .pin(in_blank),
    .level(blank_lvl_unused), .rise(blank_rise), .fall(blank_fall));

  hub75_pin_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_row_clk (
    .sys_clk(sys_clk), .rst(rst), .pin(in_row_clk),
    .level(row_lvl_unused), .rise(row_rise), .fall(row_fall_unused));

  hub75_pin_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_row_data (
    .sys_clk(sys_clk), .rst(rst), .pin(in_row_data),
    .level(row_data_lvl), .rise(row_data_rise_unused), .fall(row_data_fall_unused));

  logic [CW-1:0]   col_cnt_q, col_cnt_d, px_col_q, px_col_d, lat_cols_q, lat_cols_d;
  logic            ovf_q, ovf_d, lat_ovf_q, lat_ovf_d;
  logic            px_valid_q, px_valid_d, lat_valid_q, lat_valid_d;
  logic [5:0]      px_rgb_q, px_rgb_d;
  logic [RW-1:0]   row_pos_q, row_pos_d, lat_row_q, lat_row_d;
  logic [RW-1:0]   on_row_q, on_row_d, on_row_cap_q, on_row_cap_d;
  logic [0:0]      row_st_q, row_st_d, on_st_q, on_st_d;
  logic            row_valid_q, row_valid_d, frame_start_q, frame_start_d;
  logic            on_valid_q, on_valid_d;
  logic [ON_W-1:0] on_cnt_q, on_cnt_d, on_cycles_q, on_cycles_d, on_cnt_inc;

  // Column shifting and latching; a same-cycle shift is counted before the latch clears.
  always_comb begin
    col_cnt_d   = col_cnt_q;
    ovf_d       = ovf_q;
    px_valid_d  = 1'b0;
    px_col_d    = px_col_q;
    px_rgb_d    = px_rgb_q;
    lat_valid_d = 1'b0;
    lat_cols_d  = lat_cols_q;
    lat_ovf_d   = lat_ovf_q;
    lat_row_d   = lat_row_q;
    if (clk_rise) begin
      px_valid_d = 1'b1;
      px_col_d   = col_cnt_q;
      px_rgb_d   = rgb_lvl;
      if (col_cnt_q == CW'(COLS)) begin
        ovf_d = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end else begin
      px_col_d = px_col_q;
    end
    if (lat_rise) begin
      lat_valid_d = 1'b1;
      lat_cols_d  = col_cnt_d;
      lat_ovf_d   = ovf_d;
      lat_row_d   = row_pos_q;
      col_cnt_d   = '0;
      ovf_d       = 1'b0;
    end else begin
      lat_row_d = lat_row_q;
    end
  end

  // Row-select token tracker.
  always_comb begin
    row_st_d      = row_st_q;
    row_pos_d     = row_pos_q;
    frame_start_d = 1'b0;
    if (row_rise) begin
      if (row_data_lvl) begin
        row_st_d      = ST_TRACKING;
        row_pos_d     = '0;
        frame_start_d = 1'b1;
      end else if (row_st_q == ST_TRACKING && row_pos_q != RW'(ROWS-1)) begin
        row_pos_d = row_pos_q + RW'(1);
      end else begin
        row_st_d  = ST_NO_TOKEN;
        row_pos_d = '0;
      end
    end else begin
      row_st_d = row_st_q;
    end
    row_valid_d = (row_st_d == ST_TRACKING);
  end

  // Lit-interval timer; the edge cycle that ends the period is itself counted.
  always_comb begin
    on_st_d      = on_st_q;
    on_cnt_d     = on_cnt_q;
    on_row_cap_d = on_row_cap_q;
    on_row_d     = on_row_q;
    on_valid_d   = 1'b0;
    on_cycles_d  = on_cycles_q;
    on_cnt_inc   = (on_cnt_q == {ON_W{1'b1}}) ? on_cnt_q : on_cnt_q + ON_W'(1);
    case (on_st_q)
      ST_BLANKED: begin
        if (blank_fall) begin
          on_st_d      = ST_LIT;
          on_cnt_d     = '0;
          on_row_cap_d = row_pos_q;
        end else begin
          on_st_d = ST_BLANKED;
        end
      end
      ST_LIT: begin
        if (blank_rise) begin
          on_st_d     = ST_BLANKED;
          on_valid_d  = 1'b1;
          on_cycles_d = on_cnt_inc;
          on_row_d    = on_row_cap_q;
        end else begin
          on_cnt_d = on_cnt_inc;
        end
      end
      default: on_st_d = ST_BLANKED;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      col_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      px_valid_q    <= 1'b0;
      px_col_q      <= '0;
      px_rgb_q      <= 6'd0;
      lat_valid_q   <= 1'b0;
      lat_cols_q    <= '0;
      lat_ovf_q     <= 1'b0;
      lat_row_q     <= '0;
      row_st_q      <= ST_NO_TOKEN;
      row_pos_q     <= '0;
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      on_st_q       <= ST_BLANKED;
      on_cnt_q      <= '0;
      on_row_cap_q  <= '0;
      on_row_q      <= '0;
      on_valid_q    <= 1'b0;
      on_cycles_q   <= '0;
    end else begin
      col_cnt_q     <= col_cnt_d;
      ovf_q         <= ovf_d;
      px_valid_q    <= px_valid_d;
      px_col_q      <= px_col_d;
      px_rgb_q      <= px_rgb_d;
      lat_valid_q   <= lat_valid_d;
      lat_cols_q    <= lat_cols_d;
      lat_ovf_q     <= lat_ovf_d;
      lat_row_q     <= lat_row_d;
      row_st_q      <= row_st_d;
      row_pos_q     <= row_pos_d;
      row_valid_q   <= row_valid_d;
      frame_start_q <= frame_start_d;
      on_st_q       <= on_st_d;
      on_cnt_q      <= on_cnt_d;
      on_row_cap_q  <= on_row_cap_d;
      on_row_q      <= on_row_d;
      on_valid_q    <= on_valid_d;
      on_cycles_q   <= on_cycles_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_col      = px_col_q;
  assign px_rgb      = px_rgb_q;
  assign lat_valid   = lat_valid_q;
  assign lat_cols    = lat_cols_q;
  assign lat_row     = lat_row_q;
  assign lat_ovf     = lat_ovf_q;
  assign on_valid    = on_valid_q;
  assign on_cycles   = on_cycles_q;
  assign on_row      = on_row_q;
  assign row_valid   = row_valid_q;
  assign frame_start = frame_start_q;

endmodule
